// File: rtl/lut_interp_server.sv
// Linear-interpolating LUT server: a single request is turned into two LUT reads, a multiply and a
// registered, signed result with a one-cycle ready pulse. The LUT is written through a separate port.
module lut_interp_server #(
  parameter int req_data_width    = 16,
  parameter int server_data_width = 16,
  parameter int lut_addr_width    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         arbiter_req,
  input  logic [req_data_width-1:0]    arbiter_req_data,
  output logic [server_data_width-1:0] server_data,
  output logic                         server_ready,
  output logic                         busy,
  output logic                         overrun,
  input  logic                         lut_wr_en,
  input  logic [lut_addr_width-1:0]    lut_wr_addr,
  input  logic [server_data_width-1:0] lut_wr_data
);

  localparam int W     = server_data_width;
  localparam int AW    = lut_addr_width;
  localparam int F     = req_data_width - lut_addr_width;
  localparam int DEPTH = 1 << AW;
  localparam int PW    = W + F + 2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH_A = 3'd1;
  localparam logic [2:0] ST_FETCH_B = 3'd2;
  localparam logic [2:0] ST_MULT    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  rd_q;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    state_q, state_d;
  logic [AW-1:0] index_q;
  logic [F-1:0]  frac_q;
  logic [W-1:0]  a_q;
  logic signed [PW-1:0] prod_q;
  logic [W-1:0]  data_q;
  logic          ready_q;
  logic          overrun_q;

  logic signed [W:0]    diff;
  logic signed [PW-1:0] diff_ext;
  logic signed [PW-1:0] frac_ext;
  logic signed [PW-1:0] prod_full;
  logic signed [PW-1:0] a_ext;

  // Read port samples the registered address, so data lags the address issue by one edge;
  // a same-address write returns the old word.
  always_ff @(posedge clk) begin
    rd_q <= mem[addr_q];
    if (lut_wr_en) begin
      mem[lut_wr_addr] <= lut_wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (arbiter_req) begin
          state_d = ST_FETCH_A;
          addr_d  = arbiter_req_data[req_data_width-1:F];
        end
      end
      ST_FETCH_A: begin
        state_d = ST_FETCH_B;
        addr_d  = index_q + AW'(1);
      end
      ST_FETCH_B: state_d = ST_MULT;
      ST_MULT:    state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // b arrives on rd_q during MULT while a has been parked in a_q.
  assign diff      = $signed({rd_q[W-1], rd_q}) - $signed({a_q[W-1], a_q});
  assign diff_ext  = PW'(diff);
  assign frac_ext  = PW'({1'b0, frac_q});
  assign prod_full = diff_ext * frac_ext;
  assign a_ext     = PW'($signed(a_q));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      index_q   <= '0;
      frac_q    <= '0;
      a_q       <= '0;
      prod_q    <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ready_q <= 1'b0;
      if (state_q == ST_IDLE && arbiter_req) begin
        index_q <= arbiter_req_data[req_data_width-1:F];
        frac_q  <= arbiter_req_data[F-1:0];
      end
      if (state_q != ST_IDLE && arbiter_req) begin
        overrun_q <= 1'b1;
      end
      if (state_q == ST_FETCH_B) begin
        a_q <= rd_q;
      end
      if (state_q == ST_MULT) begin
        prod_q <= prod_full;
      end
      if (state_q == ST_DONE) begin
        data_q  <= W'(a_ext + (prod_q >>> F));
        ready_q <= 1'b1;
      end
    end
  end

  assign server_data  = data_q;
  assign server_ready = ready_q;
  assign busy         = (state_q != ST_IDLE);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_lut_interp_server.sv
// Bench for lut_interp_server: table-driven interpolation vectors checked through a result
// scoreboard, plus hand-written overrun, reset-abort and write-during-operation sequences.
module tb_lut_interp_server;

  logic        clk;
  logic        rst_n;
  logic        arbiter_req;
  logic [15:0] arbiter_req_data;
  logic [15:0] server_data;
  logic        server_ready;
  logic        busy;
  logic        overrun;
  logic        lut_wr_en;
  logic [7:0]  lut_wr_addr;
  logic [15:0] lut_wr_data;

  int checks = 0;
  int errors = 0;
  int ready_cnt = 0;
  logic signed [15:0] sb_q[$];

  typedef struct {
    logic [7:0]         idx;
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic [15:0]        phase;
    logic signed [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  lut_interp_server dut (
    .clk              (clk),
    .reset            (rst_n),
    .arbiter_req      (arbiter_req),
    .arbiter_req_data (arbiter_req_data),
    .server_data      (server_data),
    .server_ready     (server_ready),
    .busy             (busy),
    .overrun          (overrun),
    .lut_wr_en        (lut_wr_en),
    .lut_wr_addr      (lut_wr_addr),
    .lut_wr_data      (lut_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Scoreboard side: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && server_ready) begin
      logic signed [15:0] e;
      ready_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready actual=%0d required=none", $signed(server_data));
      end else begin
        e = sb_q.pop_front();
        check_int("result", int'($signed(server_data)), int'(e));
        $display("result %0d expected %0d", $signed(server_data), e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lut_write(input logic [7:0] addr, input logic [15:0] data);
    lut_wr_en   = 1'b1;
    lut_wr_addr = addr;
    lut_wr_data = data;
    tick();
    lut_wr_en   = 1'b0;
  endtask

  task automatic issue(input logic [15:0] phase);
    arbiter_req      = 1'b1;
    arbiter_req_data = phase;
    tick();
    arbiter_req      = 1'b0;
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (server_ready) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int rc;
    logic [7:0] nx;

    vecs[0] = '{idx: 8'h10, a: 16'sd1000,   b: 16'sd2000,  phase: 16'h1080, exp: 16'sd1500};
    vecs[1] = '{idx: 8'h20, a: 16'sd100,    b: -16'sd100,  phase: 16'h2001, exp: 16'sd99};
    vecs[2] = '{idx: 8'h20, a: 16'sd100,    b: -16'sd100,  phase: 16'h2000, exp: 16'sd100};
    vecs[3] = '{idx: 8'hFF, a: -16'sd32768, b: 16'sd32767, phase: 16'hFFFF, exp: 16'sd32511};
    vecs[4] = '{idx: 8'h30, a: -16'sd500,   b: 16'sd500,   phase: 16'h3040, exp: -16'sd250};
    vecs[5] = '{idx: 8'h40, a: 16'sd7,      b: 16'sd8,     phase: 16'h40FF, exp: 16'sd7};
    vecs[6] = '{idx: 8'h50, a: 16'sd32767,  b: -16'sd32768, phase: 16'h5080, exp: -16'sd1};

    rst_n = 1'b0;
    arbiter_req = 1'b0;
    arbiter_req_data = '0;
    lut_wr_en = 1'b0;
    lut_wr_addr = '0;
    lut_wr_data = '0;
    #3;
    check_int("rst_data", int'(server_data), 0);
    check_int("rst_ready", int'(server_ready), 0);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_overrun", int'(overrun), 0);
    #4 rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      nx = vecs[i].idx + 8'd1;
      lut_write(vecs[i].idx, vecs[i].a);
      lut_write(nx, vecs[i].b);
      sb_q.push_back(vecs[i].exp);
      issue(vecs[i].phase);
      check_int("busy_after_accept", int'(busy), 1);
      wait_ready(lat);
      check_int("latency", lat, 4);
      check_int("busy_at_ready", int'(busy), 0);
      tick();
      check_int("ready_one_cycle", int'(server_ready), 0);
      check_int("data_hold", int'($signed(server_data)), int'(vecs[i].exp));
    end

    // Second request two edges into an operation is dropped and latches overrun.
    lut_write(8'h10, 16'd1000);
    lut_write(8'h11, 16'd2000);
    rc = ready_cnt;
    sb_q.push_back(16'sd1500);
    issue(16'h1080);
    tick();
    issue(16'h2000);
    wait_ready(lat);
    check_int("ovr_latency_rest", lat, 2);
    check_int("overrun_set", int'(overrun), 1);
    sb_q.push_back(16'sd1500);
    issue(16'h1080);
    wait_ready(lat);
    check_int("e5_accept_latency", lat, 4);
    repeat (3) tick();
    check_int("ovr_ready_count", ready_cnt - rc, 2);
    check_int("overrun_sticky", int'(overrun), 1);

    // Reset in FETCH_B aborts without a ready pulse.
    rc = ready_cnt;
    issue(16'h1080);
    tick();
    rst_n = 1'b0;
    #1;
    check_int("abort_busy", int'(busy), 0);
    check_int("abort_data", int'(server_data), 0);
    check_int("abort_overrun", int'(overrun), 0);
    #2 rst_n = 1'b1;
    repeat (6) tick();
    check_int("abort_no_ready", ready_cnt - rc, 0);
    sb_q.push_back(16'sd1500);
    issue(16'h1080);
    wait_ready(lat);
    check_int("post_reset_latency", lat, 4);

    // LUT write at E1 lands before b is read.
    tick();
    sb_q.push_back(16'sd2000);
    issue(16'h1080);
    lut_write(8'h11, 16'd3000);
    wait_ready(lat);
    check_int("wr_during_op_latency", lat, 3);
    tick();
    sb_q.push_back(16'sd2000);
    issue(16'h1080);
    wait_ready(lat);
    check_int("wr_repeat_latency", lat, 4);

    repeat (3) tick();
    check_int("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
